fft_frame_sequencer: RTL and testbench

- Sequences the radix-2 FFT core across one frame: load, start, compute, capture, drain.
- Accepts an 8-bit sample stream, writes POINTS samples into the FFT as zero-padded complex words, then pulses start.
- Captures the POINTS-word burst the FFT emits while done is high into a local result buffer, because the FFT cannot be stalled.
- Drains the buffer to a downstream consumer over valid/ready. Sits between the SPI/ADC sample adapter and the spectrum post-processing.

---
 rtl/fft_frame_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// Runs one FFT frame: load POINTS samples, pulse start, capture the unstallable result burst, drain it.
// Load-to-start is 1 cycle; drain adds 1 prefetch cycle and then stalls cleanly on out_ready.
module fft_frame_sequencer #(
  parameter int M       = 9,
  parameter int WIDTH   = 16,
  parameter int POINTS  = 2**M,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               sample_valid,
  input  logic [7:0]         sample_data,
  output logic               sample_ready,
  output logic               fft_load,
  output logic [M-1:0]       fft_rd_adr,
  output logic [2*WIDTH-1:0] fft_rd,
  output logic               fft_start,
  input  logic               fft_done,
  input  logic [2*WIDTH-1:0] fft_wd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic [M-1:0]       out_idx,
  output logic               busy,
  output logic               overrun,
  output logic               timeout_err,
  output logic [15:0]        frame_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [M-1:0] LAST = M'(POINTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_COMPUTE,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [M-1:0]       r_ld_cnt;
  logic [M-1:0]       r_cap_cnt;
  logic [M-1:0]       r_out_idx;
  logic [TW-1:0]      r_wait_cnt;
  logic               r_out_valid;
  logic               r_overrun;
  logic               r_timeout_err;
  logic [15:0]        r_frame_count;
  logic [2*WIDTH-1:0] r_mem [POINTS];
  logic [2*WIDTH-1:0] r_ram_q;

  logic               w_cap_we;
  logic               w_to_set;
  logic               w_frame_done;
  logic [M-1:0]       w_ram_adr;
  logic [TW-1:0]      w_wait_inc;
  logic               w_wait_expire;

  assign w_wait_inc    = r_wait_cnt + 1'b1;
  assign w_wait_expire = (w_wait_inc == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    sample_ready = 1'b0;
    fft_load     = 1'b0;
    fft_rd_adr   = '0;
    fft_rd       = '0;
    fft_start    = 1'b0;
    w_cap_we     = 1'b0;
    w_to_set     = 1'b0;
    w_frame_done = 1'b0;
    w_ram_adr    = r_cap_cnt;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        sample_ready = 1'b1;
        if (sample_valid) begin
          fft_load   = 1'b1;
          fft_rd_adr = r_ld_cnt;
          fft_rd     = {{(WIDTH-8){1'b0}}, sample_data, {WIDTH{1'b0}}};
          if (r_ld_cnt == LAST) w_state_nxt = S_START;
        end
      end
      S_START: begin
        fft_start   = 1'b1;
        w_state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (fft_done) begin
          w_cap_we    = 1'b1;
          w_state_nxt = S_CAPTURE;
        end else if (w_wait_expire) begin
          w_to_set    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CAPTURE: begin
        if (fft_done) begin
          w_cap_we = 1'b1;
          if (r_cap_cnt == LAST) w_state_nxt = S_DRAIN;
        end else begin
          // A short burst leaves a partial spectrum; abandon it like a timeout.
          w_to_set    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        w_ram_adr = r_out_idx;
        if (!r_out_valid) begin
          w_ram_adr = '0;
        end else if (out_ready) begin
          if (r_out_idx == LAST) begin
            w_frame_done = 1'b1;
            w_state_nxt  = enable ? S_LOAD : S_IDLE;
          end else begin
            w_ram_adr = r_out_idx + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ld_cnt      <= '0;
      r_cap_cnt     <= '0;
      r_wait_cnt    <= '0;
      r_out_idx     <= '0;
      r_out_valid   <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_count <= '0;
    end else begin
      // ld_cnt wraps to 0 on the last beat, ready for the next frame.
      if (fft_load) begin
        r_ld_cnt <= r_ld_cnt + 1'b1;
      end else if (r_state == S_IDLE) begin
        r_ld_cnt <= '0;
      end

      if (w_cap_we) begin
        r_cap_cnt <= r_cap_cnt + 1'b1;
      end else begin
        r_cap_cnt <= '0;
      end

      if (r_state == S_COMPUTE) begin
        r_wait_cnt <= w_wait_inc;
      end else begin
        r_wait_cnt <= '0;
      end

      if (sample_valid && (r_state != S_LOAD)) r_overrun <= 1'b1;
      if (w_to_set) r_timeout_err <= 1'b1;

      if (r_state == S_DRAIN) begin
        if (!r_out_valid) begin
          r_out_valid <= 1'b1;
          r_out_idx   <= '0;
        end else if (out_ready) begin
          if (w_frame_done) begin
            r_out_valid   <= 1'b0;
            r_out_idx     <= '0;
            r_frame_count <= r_frame_count + 1'b1;
          end else begin
            r_out_idx <= r_out_idx + 1'b1;
          end
        end
      end
    end
  end

  // Single-port result buffer; the read address replays out_idx while stalled.
  always_ff @(posedge clk) begin
    if (w_cap_we) r_mem[w_ram_adr] <= fft_wd;
    r_ram_q <= r_mem[w_ram_adr];
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_valid ? r_ram_q : '0;
  assign out_idx     = r_out_idx;
  assign busy        = (r_state != S_IDLE);
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized bench for fft_frame_sequencer with a behavioural FFT burst source and result scoreboard.
module tb_fft_frame_sequencer;

  localparam int M      = 9;
  localparam int WIDTH  = 16;
  localparam int POINTS = 2**M;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              sample_valid;
  logic [7:0]        sample_data;
  logic              sample_ready;
  logic              fft_load;
  logic [M-1:0]      fft_rd_adr;
  logic [31:0]       fft_rd;
  logic              fft_start;
  logic              fft_done;
  logic [31:0]       fft_wd;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_data;
  logic [M-1:0]      out_idx;
  logic              busy;
  logic              overrun;
  logic              timeout_err;
  logic [15:0]       frame_count;

  fft_frame_sequencer #(.M(M), .WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .fft_load(fft_load), .fft_rd_adr(fft_rd_adr), .fft_rd(fft_rd), .fft_start(fft_start),
    .fft_done(fft_done), .fft_wd(fft_wd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .overrun(overrun), .timeout_err(timeout_err), .frame_count(frame_count)
  );

  initial forever #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 0;
  bit          drain_ok = 0;
  int          ready_mode = 0;
  int          mon_adr = 0;
  int          exp_idx = 0;
  int          hs = 0;
  logic [15:0] exp_fc = '0;
  logic        exp_ovr = 1'b0;
  logic        exp_to = 1'b0;
  logic [31:0] exp_words [POINTS];
  logic        beat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sample_ready"}, sample_ready, 0);
    chk({tag, "_fft_load"}, fft_load, 0);
    chk({tag, "_fft_start"}, fft_start, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_fft_rd_adr"}, fft_rd_adr, 0);
    chk({tag, "_fft_rd"}, fft_rd, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
  endtask

  // Load side: every accepted beat must appear on the FFT load port at the next contiguous address.
  always @(negedge clk) begin
    if (mon_en) begin
      beat = sample_valid && sample_ready;
      chk("fft_load", fft_load, beat);
      chk("load_start_excl", fft_load & fft_start, 0);
      if (beat) begin
        chk("fft_rd_adr", fft_rd_adr, mon_adr);
        chk("fft_rd", fft_rd, {8'h00, sample_data, 16'h0000});
        mon_adr++;
      end
    end
  end

  // Drain side: words must come out in bin order, held while stalled, none lost or repeated.
  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      chk("out_valid_allowed", drain_ok, 1);
      chk("out_idx", out_idx, exp_idx);
      if (exp_idx < POINTS) chk("out_data", out_data, exp_words[exp_idx]);
      if (out_ready) begin
        exp_idx++;
        hs++;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_frame(input int gap, input int fixed, input int stop);
    int n, g, t;
    bit seen;
    n = 0; g = 0; t = 0; seen = 0;
    while (n < stop && g < 4000) begin
      @(negedge clk);
      if (sample_valid && sample_ready) n++;
      if (sample_ready) seen = 1;
      @(posedge clk);
      #1;
      g++;
      if (seen && n < stop) begin
        sample_valid = (gap == 0) || ((t % gap) != gap - 1);
        sample_data  = (fixed >= 0) ? 8'(fixed) : 8'($urandom);
        t++;
      end
    end
    sample_valid = 1'b0;
    chk("load_beats", n, stop);
  endtask

  task automatic run_frame(input int gap, input int fixed, input int rmode, input bit hold, input bit ramp);
    int g;
    mon_adr    = 0;
    ready_mode = rmode;
    load_frame(gap, fixed, POINTS);
    if (hold) begin
      sample_valid = 1'b1;
      sample_data  = 8'hAA;
      exp_ovr      = 1'b1;
    end
    @(negedge clk);
    chk("start_after_last_beat", fft_start, 1);
    chk("busy_start", busy, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < POINTS; k++) exp_words[k] = ramp ? 32'(k) : $urandom;
    exp_idx  = 0;
    hs       = 0;
    drain_ok = 1;
    @(negedge clk);
    chk("start_single_pulse", fft_start, 0);
    @(posedge clk);
    #1;
    repeat ($urandom_range(0, 40)) begin
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < POINTS; k++) begin
      fft_done = 1'b1;
      fft_wd   = exp_words[k];
      @(posedge clk);
      #1;
    end
    fft_done = 1'b0;
    fft_wd   = '0;
    g = 0;
    while (hs < POINTS && g < 4000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("handshakes", hs, POINTS);
    exp_fc++;
    chk("frame_count", frame_count, exp_fc);
    chk("out_valid_after_last", out_valid, 0);
    chk("overrun", overrun, exp_ovr);
    chk("timeout_err", timeout_err, exp_to);
    drain_ok = 0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_data = '0;
    fft_done = 1'b0; fft_wd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_without_enable", busy, 0);
    mon_en = 1;
    enable = 1'b1;

    run_frame(0, 8'h10, 0, 0, 1);     // back-to-back constant samples, ramp spectrum
    run_frame(3, -1, 2, 0, 0);        // gap every 3rd cycle, random drain stalls
    run_frame(0, -1, 1, 0, 0);        // out_ready toggling
    run_frame(0, -1, 0, 1, 0);        // valid held through compute/drain
    run_frame(3, -1, 2, 0, 0);

    // FFT never answers: compute must give up after TMO cycles.
    mon_adr    = 0;
    ready_mode = 0;
    load_frame(0, -1, POINTS);
    enable = 1'b0;
    @(negedge clk);
    chk("to_start", fft_start, 1);
    repeat (TMO) @(negedge clk);
    chk("to_not_yet", timeout_err, 0);
    chk("to_busy_compute", busy, 1);
    @(negedge clk);
    exp_to = 1'b1;
    chk("to_set", timeout_err, exp_to);
    chk("to_idle", busy, 0);
    chk("to_frame_count", frame_count, exp_fc);
    repeat (5) @(negedge clk);
    chk("to_stays_idle", busy, 0);
    chk("to_sticky", timeout_err, exp_to);
    chk("to_overrun_sticky", overrun, exp_ovr);

    // Reset in the middle of a load, then a clean frame.
    @(posedge clk);
    #1;
    enable  = 1'b1;
    mon_adr = 0;
    load_frame(0, -1, 200);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("midreset");
    reset   = 1'b1;
    exp_fc  = '0;
    exp_ovr = 1'b0;
    exp_to  = 1'b0;
    run_frame(0, -1, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
